// File: rtl/fetch_redirect_ctrl_pkg.sv
// fetch_ctrl_pkg: shared types and constants for the fetch redirect controller
package fetch_ctrl_pkg;
  typedef enum logic {RUN, FLUSH} state_e;
  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } upd_entry_t;
  localparam logic [31:0] PC_INC = 32'd4;
endpackage

// File: rtl/fetch_redirect_ctrl_if.sv
// fetch_redirect_ctrl_if: resolution, redirect, training-update and statistics signals
interface fetch_redirect_ctrl_if #(parameter int CNT_W = 16);
  logic             stall_in;
  logic             res_valid;
  logic [31:0]      res_pc;
  logic             res_taken;
  logic             res_pred_taken;
  logic [31:0]      res_target;
  logic [31:0]      res_pred_target;
  logic             pc_write;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             flush_if;
  logic             flush_id;
  logic             upd_valid;
  logic             upd_ready;
  logic [31:0]      upd_pc;
  logic             upd_taken;
  logic [31:0]      upd_target;
  logic             upd_overflow;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;
  modport master (
    input  stall_in, res_valid, res_pc, res_taken, res_pred_taken, res_target, res_pred_target, upd_ready,
    output pc_write, redirect_valid, redirect_pc, flush_if, flush_id,
           upd_valid, upd_pc, upd_taken, upd_target, upd_overflow, branch_cnt, mispred_cnt
  );
  modport slave (
    output stall_in, res_valid, res_pc, res_taken, res_pred_taken, res_target, res_pred_target, upd_ready,
    input  pc_write, redirect_valid, redirect_pc, flush_if, flush_id,
           upd_valid, upd_pc, upd_taken, upd_target, upd_overflow, branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/fetch_redirect_ctrl_upd_fifo.sv
// upd_fifo: synchronous FIFO for predictor-training updates; push while full is accepted only with a pop
module upd_fifo
  import fetch_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  upd_entry_t din,
  output logic       full,
  output logic       empty,
  output upd_entry_t head
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_q, rd_q;
  logic        wr_en, rd_en;
  upd_entry_t  mem [DEPTH];
  assign empty = wr_q == rd_q;
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);
  assign head  = mem[rd_q[AW-1:0]];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_q + (AW+1)'(wr_en);
      rd_q <= rd_q + (AW+1)'(rd_en);
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl: mispredict detection, PC redirect/flush sequencing, training-update buffering and branch statistics
module fetch_redirect_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int UPD_DEPTH    = 4,
  parameter int CNT_W        = 16
) (
  input logic                  clk,
  input logic                  rst,
  fetch_redirect_ctrl_if.master bus
);
  state_e           state_q, state_d;
  logic [2:0]       fcnt_q, fcnt_d;
  logic             redir_v_q;
  logic [31:0]      redir_pc_q;
  logic             ovf_q;
  logic [CNT_W-1:0] branch_cnt_q, mispred_cnt_q;
  logic             accept, mispred, full, empty, pop;
  upd_entry_t       head;
  assign accept  = bus.res_valid && state_q == RUN;
  assign mispred = accept && ((bus.res_taken != bus.res_pred_taken) ||
                              (bus.res_taken && bus.res_target != bus.res_pred_target));
  assign pop     = ~empty & bus.upd_ready;
  upd_fifo #(.DEPTH(UPD_DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (accept),
    .pop  (pop),
    .din  ('{pc: bus.res_pc, taken: bus.res_taken, target: bus.res_target}),
    .full (full),
    .empty(empty),
    .head (head)
  );
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    if (state_q == FLUSH) begin
      fcnt_d  = fcnt_q - 3'd1;
      state_d = fcnt_q == 3'd1 ? RUN : FLUSH;
    end
    if (mispred) begin
      state_d = FLUSH;
      fcnt_d  = 3'(FLUSH_CYCLES);
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= RUN;
      fcnt_q        <= '0;
      redir_v_q     <= 1'b0;
      redir_pc_q    <= '0;
      ovf_q         <= 1'b0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      redir_v_q <= mispred;
      if (mispred) redir_pc_q <= bus.res_taken ? bus.res_target : bus.res_pc + PC_INC;
      ovf_q <= ovf_q | (accept & full & ~pop);
      if (accept && branch_cnt_q != '1) branch_cnt_q <= branch_cnt_q + CNT_W'(1);
      if (mispred && mispred_cnt_q != '1) mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
    end
  end
  // a pending redirect must load the PC even if the hazard unit is stalling
  assign bus.pc_write       = redir_v_q | (~bus.stall_in & ~(full & ~pop));
  assign bus.redirect_valid = redir_v_q;
  assign bus.redirect_pc    = redir_pc_q;
  assign bus.flush_if       = state_q == FLUSH;
  assign bus.flush_id       = state_q == FLUSH;
  assign bus.upd_valid      = ~empty;
  assign bus.upd_pc         = empty ? '0 : head.pc;
  assign bus.upd_taken      = ~empty & head.taken;
  assign bus.upd_target     = empty ? '0 : head.target;
  assign bus.upd_overflow   = ovf_q;
  assign bus.branch_cnt     = branch_cnt_q;
  assign bus.mispred_cnt    = mispred_cnt_q;
endmodule
